// File: rtl/spoc_absorb_if.sv
// ---------------------------------------------------------------------------
// spoc_absorb_if
// Handshake bundle between a bdi word producer / block consumer and
// spoc_absorb_buffer.
//
// Parameters:
//   PW    input word width in bits (8, 16 or 32)
//   RATE  block width in bits (64 or 128)
//
// Signals:
//   in_valid, in_ready, in_data[PW], in_size, in_last     word side
//   out_valid, out_ready, out_block[RATE], out_size,
//   out_partial, out_last                                 block side
//   err                                                   sticky protocol error
//   out_mask[RATE/8]                                      only with SPOC_ABSORB_MASK_EN
//
// Modports:
//   master  the environment (drives words, accepts blocks)
//   slave   the buffer itself
//
// Optional feature macro: SPOC_ABSORB_MASK_EN adds out_mask.
// ---------------------------------------------------------------------------
interface spoc_absorb_if #(
    parameter int unsigned PW   = 32,
    parameter int unsigned RATE = 64
);
    localparam int unsigned SW = $clog2(PW / 8) + 1;
    localparam int unsigned OW = $clog2(RATE / 8) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_data;
    logic [SW-1:0]    in_size;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [RATE-1:0]  out_block;
    logic [OW-1:0]    out_size;
    logic             out_partial;
    logic             out_last;
    logic             err;
`ifdef SPOC_ABSORB_MASK_EN
    logic [RATE/8-1:0] out_mask;

    modport master (
        output in_valid, in_data, in_size, in_last, out_ready,
        input  in_ready, out_valid, out_block, out_size, out_partial,
               out_last, err, out_mask
    );

    modport slave (
        input  in_valid, in_data, in_size, in_last, out_ready,
        output in_ready, out_valid, out_block, out_size, out_partial,
               out_last, err, out_mask
    );
`else
    modport master (
        output in_valid, in_data, in_size, in_last, out_ready,
        input  in_ready, out_valid, out_block, out_size, out_partial,
               out_last, err
    );

    modport slave (
        input  in_valid, in_data, in_size, in_last, out_ready,
        output in_ready, out_valid, out_block, out_size, out_partial,
               out_last, err
    );
`endif
endinterface

// File: rtl/spoc_absorb_buffer.sv
// ---------------------------------------------------------------------------
// spoc_absorb_buffer
// Block-assembly buffer for the SpoC AEAD datapaths. PW-bit bdi words are
// packed MSB-first into a RATE-bit block; partial blocks receive 10* byte
// padding (PAD_BYTE then zeros) and each finished block is handed to the
// permutation stage over a valid/ready handshake.
//
// Parameters:
//   PW        input word width (8, 16, 32)
//   RATE      block width (64 = SpoC-64, 128 = SpoC-128), multiple of PW
//   PAD_BYTE  first padding byte
//
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   clr   synchronous flush (returns everything, including err, to reset)
//   bus   spoc_absorb_if.slave (word input, block output, err, out_mask)
//
// Optional feature macro: SPOC_ABSORB_MASK_EN
//   When defined, bus.out_mask[RATE/8-1:0] flags data bytes of the block
//   (MSB bit = byte 0). When undefined the port is absent.
//
// Two states: FILL accepts one word per cycle, HOLD presents the padded
// block until the consumer takes it. All block-side outputs are registered;
// the padded image is computed from the next-state data at the closing word
// so out_valid and the block appear together one cycle after acceptance.
// ---------------------------------------------------------------------------
module spoc_absorb_buffer #(
    parameter int unsigned PW       = 32,
    parameter int unsigned RATE     = 64,
    parameter logic [7:0]  PAD_BYTE = 8'h80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    spoc_absorb_if.slave  bus
);

    localparam int unsigned PB    = PW / 8;            // bytes per word
    localparam int unsigned NB    = RATE / 8;          // bytes per block
    localparam int unsigned WORDS = RATE / PW;         // words per block
    localparam int unsigned SW    = $clog2(PB) + 1;    // in_size width
    localparam int unsigned OW    = $clog2(NB) + 1;    // out_size width
    localparam int unsigned CW    = $clog2(WORDS) + 1; // word counter width

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Build the padded block: data bytes below n, PAD_BYTE at n, zeros after.
    function automatic logic [RATE-1:0] pad_block(
        input logic [RATE-1:0] data,
        input logic [OW-1:0]   n
    );
        logic [RATE-1:0] res;
        res = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (OW'(i) < n) begin
                res[RATE-1-8*i -: 8] = data[RATE-1-8*i -: 8];
            end else if (OW'(i) == n) begin
                res[RATE-1-8*i -: 8] = PAD_BYTE;
            end else begin
                res[RATE-1-8*i -: 8] = 8'h00;
            end
        end
        return res;
    endfunction

`ifdef SPOC_ABSORB_MASK_EN
    // Byte-valid mask: bit NB-1-i is set when byte i carries data.
    function automatic logic [NB-1:0] data_mask(input logic [OW-1:0] n);
        logic [NB-1:0] res;
        res = '0;
        for (int i = 0; i < int'(NB); i++) begin
            res[NB-1-i] = (OW'(i) < n);
        end
        return res;
    endfunction
`endif

    // Architectural state and registered outputs.
    state_t          state_r;
    logic [CW-1:0]   word_cnt_r;
    logic [OW-1:0]   byte_cnt_r;
    logic [RATE-1:0] data_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [RATE-1:0] out_block_r;
    logic [OW-1:0]   out_size_r;
    logic            out_partial_r;
    logic            out_last_r;
    logic            err_r;
`ifdef SPOC_ABSORB_MASK_EN
    logic [NB-1:0]   out_mask_r;
`endif

    // Next-word combinational path.
    logic            accept_s;
    logic            size_over_s;
    logic            size_short_s;
    logic [SW-1:0]   size_eff_s;
    logic [PW-1:0]   word_masked_s;
    logic [RATE-1:0] data_next_s;
    logic [OW-1:0]   bytes_next_s;
    logic            close_s;
    logic            err_set_s;

    // Size sanitising, byte masking and placement of the incoming word.
    always_comb begin
        accept_s      = bus.in_valid & in_ready_r;
        size_over_s   = (bus.in_size > SW'(PB));
        size_eff_s    = bus.in_size;
        size_short_s  = 1'b0;
        word_masked_s = '0;
        data_next_s   = data_r;

        // Oversized counts are clamped to a full word.
        if (size_over_s) begin
            size_eff_s = SW'(PB);
        end else begin
            size_eff_s = bus.in_size;
        end

        // A short word is only legal as the final word of a segment.
        if (!size_over_s && (bus.in_size < SW'(PB)) && !bus.in_last) begin
            size_short_s = 1'b1;
        end else begin
            size_short_s = 1'b0;
        end

        // Bytes at or beyond the valid count are stored as zero so padding
        // lands on a clean field.
        for (int b = 0; b < int'(PB); b++) begin
            if (SW'(b) < size_eff_s) begin
                word_masked_s[PW-1-8*b -: 8] = bus.in_data[PW-1-8*b -: 8];
            end else begin
                word_masked_s[PW-1-8*b -: 8] = 8'h00;
            end
        end

        // Word k goes to the k-th PW slot counted from the MSB end.
        for (int w = 0; w < int'(WORDS); w++) begin
            if (CW'(w) == word_cnt_r) begin
                data_next_s[RATE-1-w*PW -: PW] = word_masked_s;
            end else begin
                data_next_s[RATE-1-w*PW -: PW] = data_r[RATE-1-w*PW -: PW];
            end
        end

        bytes_next_s = byte_cnt_r + OW'(size_eff_s);
        // A short non-last word cannot be followed contiguously, so it
        // closes the block early as well.
        close_s      = bus.in_last | size_short_s |
                       (word_cnt_r == CW'(WORDS - 1));
        err_set_s    = size_over_s | size_short_s;
    end

    // FILL/HOLD state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_FILL;
            word_cnt_r    <= '0;
            byte_cnt_r    <= '0;
            data_r        <= '0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_block_r   <= '0;
            out_size_r    <= '0;
            out_partial_r <= 1'b0;
            out_last_r    <= 1'b0;
            err_r         <= 1'b0;
`ifdef SPOC_ABSORB_MASK_EN
            out_mask_r    <= '0;
`endif
        end else if (clr) begin
            state_r       <= ST_FILL;
            word_cnt_r    <= '0;
            byte_cnt_r    <= '0;
            data_r        <= '0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_block_r   <= '0;
            out_size_r    <= '0;
            out_partial_r <= 1'b0;
            out_last_r    <= 1'b0;
            err_r         <= 1'b0;
`ifdef SPOC_ABSORB_MASK_EN
            out_mask_r    <= '0;
`endif
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (accept_s) begin
                        data_r     <= data_next_s;
                        byte_cnt_r <= bytes_next_s;
                        word_cnt_r <= word_cnt_r + CW'(1);
                        err_r      <= err_r | err_set_s;
                        if (close_s) begin
                            state_r       <= ST_HOLD;
                            in_ready_r    <= 1'b0;
                            out_valid_r   <= 1'b1;
                            out_block_r   <= pad_block(data_next_s, bytes_next_s);
                            out_size_r    <= bytes_next_s;
                            out_partial_r <= (bytes_next_s < OW'(NB));
                            out_last_r    <= bus.in_last;
`ifdef SPOC_ABSORB_MASK_EN
                            out_mask_r    <= data_mask(bytes_next_s);
`endif
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_HOLD: begin
                    // Consumption returns to FILL; no word is taken this cycle
                    // because in_ready is still low.
                    if (bus.out_ready) begin
                        state_r       <= ST_FILL;
                        word_cnt_r    <= '0;
                        byte_cnt_r    <= '0;
                        data_r        <= '0;
                        in_ready_r    <= 1'b1;
                        out_valid_r   <= 1'b0;
                        out_block_r   <= '0;
                        out_size_r    <= '0;
                        out_partial_r <= 1'b0;
                        out_last_r    <= 1'b0;
`ifdef SPOC_ABSORB_MASK_EN
                        out_mask_r    <= '0;
`endif
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r       <= ST_FILL;
                    word_cnt_r    <= '0;
                    byte_cnt_r    <= '0;
                    data_r        <= '0;
                    in_ready_r    <= 1'b1;
                    out_valid_r   <= 1'b0;
                    out_block_r   <= '0;
                    out_size_r    <= '0;
                    out_partial_r <= 1'b0;
                    out_last_r    <= 1'b0;
`ifdef SPOC_ABSORB_MASK_EN
                    out_mask_r    <= '0;
`endif
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_block   = out_block_r;
    assign bus.out_size    = out_size_r;
    assign bus.out_partial = out_partial_r;
    assign bus.out_last    = out_last_r;
    assign bus.err         = err_r;
`ifdef SPOC_ABSORB_MASK_EN
    assign bus.out_mask    = out_mask_r;
`endif

endmodule

// File: tb/tb_spoc_absorb_buffer.sv
// ---------------------------------------------------------------------------
// tb_spoc_absorb_buffer
// Directed bench for spoc_absorb_buffer: one instance at PW=32/RATE=64 and
// one at PW=32/RATE=128. Inputs change on the falling edge, outputs are
// sampled on the falling edge after the rising edge that acted on them.
// ---------------------------------------------------------------------------
module tb_spoc_absorb_buffer;

    logic clk;
    logic rst;
    logic clr;
    int   checks;
    int   failures;

    spoc_absorb_if #(.PW(32), .RATE(64))  a ();
    spoc_absorb_if #(.PW(32), .RATE(128)) b ();

    spoc_absorb_buffer #(.PW(32), .RATE(64), .PAD_BYTE(8'h80)) dut64 (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (a.slave)
    );

    spoc_absorb_buffer #(.PW(32), .RATE(128), .PAD_BYTE(8'h80)) dut128 (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 128'(obs), 128'(exp));
    endtask

    // Full block-side check of the RATE=64 instance while it holds a block.
    task automatic chk_a(input string tag, input logic [63:0] blk, input logic [3:0] sz,
                         input logic p, input logic l, input logic e);
        chk1({tag, "_valid"}, a.out_valid, 1'b1);
        chk1({tag, "_ready"}, a.in_ready, 1'b0);
        chk({tag, "_block"}, 128'(a.out_block), 128'(blk));
        chk({tag, "_size"}, 128'(a.out_size), 128'(sz));
        chk1({tag, "_partial"}, a.out_partial, p);
        chk1({tag, "_last"}, a.out_last, l);
        chk1({tag, "_err"}, a.err, e);
    endtask

    task automatic put_a(input logic [31:0] d, input logic [2:0] s, input logic l);
        a.in_valid = 1'b1;
        a.in_data  = d;
        a.in_size  = s;
        a.in_last  = l;
        @(negedge clk);
        a.in_valid = 1'b0;
        a.in_last  = 1'b0;
    endtask

    task automatic put_b(input logic [31:0] d, input logic [2:0] s, input logic l);
        b.in_valid = 1'b1;
        b.in_data  = d;
        b.in_size  = s;
        b.in_last  = l;
        @(negedge clk);
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
    endtask

    task automatic consume_a(input string tag);
        a.out_ready = 1'b1;
        @(negedge clk);
        a.out_ready = 1'b0;
        chk1({tag, "_drained"}, a.out_valid, 1'b0);
        chk1({tag, "_reopen"}, a.in_ready, 1'b1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        clr         = 1'b0;
        a.in_valid  = 1'b0;
        a.in_data   = '0;
        a.in_size   = '0;
        a.in_last   = 1'b0;
        a.out_ready = 1'b0;
        b.in_valid  = 1'b0;
        b.in_data   = '0;
        b.in_size   = '0;
        b.in_last   = 1'b0;
        b.out_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        chk1("rst_ready", a.in_ready, 1'b1);
        chk1("rst_valid", a.out_valid, 1'b0);
        chk("rst_block", 128'(a.out_block), 128'(0));
        chk("rst_size", 128'(a.out_size), 128'(0));
        chk1("rst_partial", a.out_partial, 1'b0);
        chk1("rst_last", a.out_last, 1'b0);
        chk1("rst_err", a.err, 1'b0);
        chk1("rst_b_ready", b.in_ready, 1'b1);
        chk1("rst_b_valid", b.out_valid, 1'b0);
`ifdef SPOC_ABSORB_MASK_EN
        chk("rst_mask", 128'(a.out_mask), 128'(0));
`endif
        rst = 1'b1;
        @(negedge clk);

        // Two full words, second is last: exactly full block, no padding.
        put_a(32'h01020304, 3'd4, 1'b0);
        chk1("full_mid_valid", a.out_valid, 1'b0);
        chk1("full_mid_ready", a.in_ready, 1'b1);
        put_a(32'h05060708, 3'd4, 1'b1);
        chk_a("full", 64'h0102030405060708, 4'd8, 1'b0, 1'b1, 1'b0);
`ifdef SPOC_ABSORB_MASK_EN
        chk("full_mask", 128'(a.out_mask), 128'(8'hFF));
`endif
        consume_a("full");

        // Three-byte last word: pad at byte 3.
        put_a(32'hAABBCCDD, 3'd3, 1'b1);
        chk_a("part3", 64'hAABBCC8000000000, 4'd3, 1'b1, 1'b1, 1'b0);
`ifdef SPOC_ABSORB_MASK_EN
        chk("part3_mask", 128'(a.out_mask), 128'(8'hE0));
`endif
        consume_a("part3");

        // Empty segment: pad byte alone.
        put_a(32'hFFFFFFFF, 3'd0, 1'b1);
        chk_a("empty", 64'h8000000000000000, 4'd0, 1'b1, 1'b1, 1'b0);
`ifdef SPOC_ABSORB_MASK_EN
        chk("empty_mask", 128'(a.out_mask), 128'(8'h00));
`endif
        consume_a("empty");

        // Zero-size last word at k=1 closes with n from word 0.
        put_a(32'h11111111, 3'd4, 1'b0);
        put_a(32'hFFFFFFFF, 3'd0, 1'b1);
        chk_a("last0_k1", 64'h1111111180000000, 4'd4, 1'b1, 1'b1, 1'b0);
        consume_a("last0_k1");

        // Short non-last word: error, early partial close, last=0.
        put_a(32'h11223344, 3'd2, 1'b0);
        chk_a("short", 64'h1122800000000000, 4'd2, 1'b1, 1'b0, 1'b1);
        // clr wins over a simultaneous consume and clears err.
        a.out_ready = 1'b1;
        do_clr();
        a.out_ready = 1'b0;
        chk1("clr_err", a.err, 1'b0);
        chk1("clr_valid", a.out_valid, 1'b0);
        chk1("clr_ready", a.in_ready, 1'b1);
        chk("clr_block", 128'(a.out_block), 128'(0));

        // Oversized count is an error and is treated as a full word.
        put_a(32'hA1A2A3A4, 3'd5, 1'b0);
        chk1("over_err", a.err, 1'b1);
        chk1("over_open", a.out_valid, 1'b0);
        put_a(32'hB1B2B3B4, 3'd4, 1'b1);
        chk_a("over", 64'hA1A2A3A4B1B2B3B4, 4'd8, 1'b0, 1'b1, 1'b1);
        do_clr();
        chk1("over_clr_err", a.err, 1'b0);

        // Asynchronous reset in HOLD discards the block immediately.
        put_a(32'h01010101, 3'd4, 1'b0);
        put_a(32'h02020202, 3'd4, 1'b0);
        chk_a("prerst", 64'h0101010102020202, 4'd8, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk1("arst_valid", a.out_valid, 1'b0);
        chk1("arst_ready", a.in_ready, 1'b1);
        chk("arst_block", 128'(a.out_block), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        put_a(32'hDEADBEEF, 3'd4, 1'b0);
        chk1("post_rst_mid", a.out_valid, 1'b0);
        put_a(32'hCAFEF00D, 3'd4, 1'b1);
        chk_a("post_rst", 64'hDEADBEEFCAFEF00D, 4'd8, 1'b0, 1'b1, 1'b0);
        consume_a("post_rst");

        // RATE=128: four full words, closes on word count with last=0.
        put_b(32'h00112233, 3'd4, 1'b0);
        put_b(32'h44556677, 3'd4, 1'b0);
        put_b(32'h8899AABB, 3'd4, 1'b0);
        chk1("b_mid_valid", b.out_valid, 1'b0);
        b.in_valid = 1'b1;
        b.in_data  = 32'hCCDDEEFF;
        b.in_size  = 3'd4;
        b.in_last  = 1'b0;
        @(negedge clk);
        // Keep offering a word while the block is held.
        b.in_data  = 32'h99999999;
        chk1("b_full_valid", b.out_valid, 1'b1);
        chk("b_full_block", 128'(b.out_block), 128'h00112233445566778899AABBCCDDEEFF);
        chk("b_full_size", 128'(b.out_size), 128'(16));
        chk1("b_full_partial", b.out_partial, 1'b0);
        chk1("b_full_last", b.out_last, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("b_hold_ready", b.in_ready, 1'b0);
            chk1("b_hold_valid", b.out_valid, 1'b1);
            chk("b_hold_block", 128'(b.out_block), 128'h00112233445566778899AABBCCDDEEFF);
        end
        // Consume with a word pending: it must not be taken in that cycle.
        b.in_data   = 32'h12345678;
        b.in_last   = 1'b1;
        b.out_ready = 1'b1;
        @(negedge clk);
        b.out_ready = 1'b0;
        chk1("b_drained", b.out_valid, 1'b0);
        chk1("b_reopen", b.in_ready, 1'b1);
        @(negedge clk);
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        chk1("b_next_valid", b.out_valid, 1'b1);
        chk("b_next_block", 128'(b.out_block), 128'h12345678800000000000000000000000);
        chk("b_next_size", 128'(b.out_size), 128'(4));
        chk1("b_next_partial", b.out_partial, 1'b1);
        chk1("b_next_last", b.out_last, 1'b1);
        chk1("b_err", b.err, 1'b0);
`ifdef SPOC_ABSORB_MASK_EN
        chk("b_next_mask", 128'(b.out_mask), 128'(16'hF000));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
